falcon5_audio: RTL and testbench



---
 rtl/falcon5_audio_if.sv | 22 ++
 rtl/falcon5_audio.sv | 134 +++++++++++++
 tb/tb_falcon5_audio.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/falcon5_audio_if.sv
// CPU-side write/status bundle of the Falcon5 audio block.
// The master drives samples into the FIFO and reads back the status flags.
interface falcon5_audio_if #(
  parameter int LVL_W = 7
);
  logic             wr_valid;
  logic [31:0]      wr_data;
  logic             clr_underflow;
  logic [LVL_W-1:0] fifo_level;
  logic             fifo_full;
  logic             underflow;

  modport master (
    output wr_valid, wr_data, clr_underflow,
    input  fifo_level, fifo_full, underflow
  );

  modport slave (
    input  wr_valid, wr_data, clr_underflow,
    output fifo_level, fifo_full, underflow
  );
endinterface

// File: rtl/falcon5_audio.sv
// Falcon5 audio output: stereo sample FIFO feeding a Philips I2S master
// (XCK = clk/4, BCLK = clk/16, 64 BCLK per frame) for a WM8731 DAC.
module falcon5_audio #(
  parameter int FIFO_DEPTH = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  falcon5_audio_if.slave         bus,
  output logic                   AUD_XCK,
  output logic                   AUD_BCLK,
  output logic                   AUD_DACLRCK,
  output logic                   AUD_DACDAT
);

  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(FIFO_DEPTH);

  // Frame timing
  logic [9:0]    cnt;
  logic          frame_end;
  logic          bclk_fall;

  // FIFO
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic          fifo_empty;
  logic          fifo_full_i;
  logic          push;
  logic          pop;

  // Serialiser
  logic [31:0]   hold;
  logic [5:0]    slot_next;
  logic [4:0]    k_next;
  logic [4:0]    bit_idx;
  logic [15:0]   chan_next;
  logic          bit_next;
  logic          lrck_q;
  logic          dat_q;
  logic          underflow_q;

  assign frame_end   = (cnt == 10'd1023);
  assign bclk_fall   = (cnt[3:0] == 4'hF);

  assign fifo_empty  = (level == '0);
  assign fifo_full_i = (level == FULL_LVL);
  // A boundary pop frees a slot before the write lands, so a full FIFO still
  // accepts a push on that cycle.
  assign pop         = frame_end && !fifo_empty;
  assign push        = bus.wr_valid && (!fifo_full_i || pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      cnt <= cnt + 10'd1;
    end
  end

  // NOTE: sample storage carries no reset; pointers and level define validity,
  // and leaving the array unreset lets it map onto RAM.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Bit to present after the coming BCLK fall: slot k drives bit 16-k for
  // k = 1..16, giving the one-BCLK I2S delay after the LRCK change.
  always_comb begin
    slot_next = cnt[9:4] + 6'd1;
    k_next    = slot_next[4:0];
    bit_idx   = 5'd16 - k_next;
    chan_next = slot_next[5] ? hold[31:16] : hold[15:0];
    bit_next  = 1'b0;
    if (k_next >= 5'd1 && k_next <= 5'd16) begin
      bit_next = chan_next[bit_idx[3:0]];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold        <= '0;
      lrck_q      <= 1'b0;
      dat_q       <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      // At the frame boundary the next slot is 0, which drives 0, so the
      // freshly loaded holding register is first used one BCLK later.
      if (frame_end) begin
        hold <= fifo_empty ? 32'd0 : mem[rd_ptr];
      end
      if (bclk_fall) begin
        lrck_q <= slot_next[5];
        dat_q  <= bit_next;
      end
      if (frame_end && fifo_empty) begin
        underflow_q <= 1'b1;
      end else if (bus.clr_underflow) begin
        underflow_q <= 1'b0;
      end
    end
  end

  assign AUD_XCK        = cnt[1];
  assign AUD_BCLK       = cnt[3];
  assign AUD_DACLRCK    = lrck_q;
  assign AUD_DACDAT     = dat_q;

  assign bus.fifo_level = level;
  assign bus.fifo_full  = fifo_full_i;
  assign bus.underflow  = underflow_q;

endmodule

// File: tb/tb_falcon5_audio.sv
// Bench for falcon5_audio: a reference FIFO/frame model fills a play queue,
// and an I2S receiver on the pins pops and compares each decoded frame.
module tb_falcon5_audio;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic aud_xck, aud_bclk, aud_lrck, aud_dat;

  falcon5_audio_if bus ();

  falcon5_audio dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus.slave),
    .AUD_XCK     (aud_xck),
    .AUD_BCLK    (aud_bclk),
    .AUD_DACLRCK (aud_lrck),
    .AUD_DACDAT  (aud_dat)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] mq[$];     // FIFO contents
  logic [31:0] play[$];   // frames scheduled for playback, oldest first
  int          tb_cnt = 0;
  logic        m_uf   = 1'b0;
  int          e_lvl = 0, e_full = 0, e_uf = 0, e_wave = 0;

  // Receiver state
  logic        rx_prev = 1'b0;
  int          rx_bit  = -1;
  logic [15:0] rx_l = '0, rx_r = '0;
  int          rx_count = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    play.delete();
    play.push_back(32'd0);
    tb_cnt = 0;
    m_uf   = 1'b0;
  endtask

  // One clock: update the model with the inputs present at the edge, then
  // sample the DUT 1 time unit later.
  task automatic tick();
    logic uf_ev;
    @(posedge clock);
    uf_ev = 1'b0;
    if (tb_cnt == 1023) begin
      if (mq.size() > 0) play.push_back(mq.pop_front());
      else begin
        play.push_back(32'd0);
        uf_ev = 1'b1;
      end
    end
    if (bus.wr_valid && mq.size() < 64) mq.push_back(bus.wr_data);
    if (uf_ev) m_uf = 1'b1;
    else if (bus.clr_underflow) m_uf = 1'b0;
    tb_cnt = (tb_cnt + 1) % 1024;
    #1;
    if (bus.fifo_level !== 7'(mq.size())) e_lvl++;
    if (bus.fifo_full !== (mq.size() == 64)) e_full++;
    if (bus.underflow !== m_uf) e_uf++;
    if (aud_xck  !== 1'((tb_cnt >> 1) & 1)) e_wave++;
    if (aud_bclk !== 1'((tb_cnt >> 3) & 1)) e_wave++;
    if (aud_lrck !== (tb_cnt >= 512)) e_wave++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [31:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  // Leaves the bench just before a 1023 -> 0 edge.
  task automatic wait_boundary();
    int guard = 0;
    while (tb_cnt != 1023 && guard < 1100) begin
      tick();
      guard++;
    end
    if (tb_cnt != 1023) check("boundary_timeout", tb_cnt, 1023);
  endtask

  task automatic phase_check(input string tag);
    check({tag, "_level_track"}, e_lvl, 0);
    check({tag, "_full_track"}, e_full, 0);
    check({tag, "_uf_track"}, e_uf, 0);
    check({tag, "_wave_track"}, e_wave, 0);
    e_lvl = 0; e_full = 0; e_uf = 0; e_wave = 0;
  endtask

  // I2S receiver: samples on BCLK rise, bit 0 after each LRCK change is the
  // delay slot, bits 1..16 are MSB..LSB. A frame completes when LRCK returns low.
  initial begin
    logic [31:0] exp;
    forever begin
      @(posedge aud_bclk or posedge reset);
      if (reset) begin
        rx_prev = 1'b0;
        rx_bit  = -1;
        rx_l    = '0;
        rx_r    = '0;
      end else begin
        if (aud_lrck != rx_prev) begin
          if (!aud_lrck) begin
            rx_count++;
            exp = (play.size() > 0) ? play.pop_front() : 32'hxxxx_xxxx;
            check("rx_pair", {rx_r, rx_l}, exp);
          end
          rx_bit = 0;
        end else begin
          rx_bit++;
        end
        if (rx_bit >= 1 && rx_bit <= 16) begin
          if (aud_lrck) rx_r = {rx_r[14:0], aud_dat};
          else          rx_l = {rx_l[14:0], aud_dat};
        end
        rx_prev = aud_lrck;
      end
    end
  end

  initial begin
    int rx_mark;
    bus.wr_valid      = 1'b0;
    bus.wr_data       = '0;
    bus.clr_underflow = 1'b0;

    // Reset state
    repeat (3) @(posedge clock);
    #2;
    check("rst_aud", {28'd0, aud_xck, aud_bclk, aud_lrck, aud_dat}, 32'd0);
    check("rst_level", bus.fifo_level, 0);
    check("rst_full", bus.fifo_full, 0);
    check("rst_uf", bus.underflow, 0);
    model_reset();
    reset = 1'b0;
    #1;
    check("release_aud", {28'd0, aud_xck, aud_bclk, aud_lrck, aud_dat}, 32'd0);

    // First frame plays zeros; one pair pushed mid-frame pops at the boundary
    for (int k = 1; k <= 1024; k++) begin
      if (k == 100) begin
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'h1234_A5A5;
      end
      tick();
      bus.wr_valid = 1'b0;
      if (k == 100)  check("single_level_up", bus.fifo_level, 1);
      if (k == 1023) check("first_frame_no_uf", bus.underflow, 0);
    end
    check("single_level_popped", bus.fifo_level, 0);
    phase_check("first");

    // Stream of 10 pairs: left = n, right = -n
    for (int n = 1; n <= 10; n++) begin
      logic [15:0] l;
      l = 16'(n);
      push({-l, l});
    end
    check("stream_level", bus.fifo_level, 10);
    for (int b = 1; b <= 11; b++) begin
      wait_boundary();
      tick();
      check($sformatf("uf_boundary%0d", b), bus.underflow, (b == 11) ? 32'd1 : 32'd0);
    end
    phase_check("stream");

    // Underflow clear, then clear colliding with a new underflow
    bus.clr_underflow = 1'b1;
    tick();
    bus.clr_underflow = 1'b0;
    check("clr_plain", bus.underflow, 0);
    wait_boundary();
    bus.clr_underflow = 1'b1;
    tick();
    bus.clr_underflow = 1'b0;
    check("clr_vs_set", bus.underflow, 1);

    // Mid-frame reset with 5 pairs queued
    for (int i = 0; i < 5; i++) push(32'hA000_0000 + 32'(i * 32'h0001_0003));
    while (tb_cnt != 600) tick();
    #1;
    reset = 1'b1;
    #1;
    check("mr_aud", {28'd0, aud_xck, aud_bclk, aud_lrck, aud_dat}, 32'd0);
    check("mr_level", bus.fifo_level, 0);
    check("mr_uf", bus.underflow, 0);
    model_reset();
    @(posedge clock);
    @(posedge clock);
    #3;
    reset = 1'b0;
    run(1100);
    phase_check("mreset");

    // Overflow: 70 back-to-back pushes, only 64 kept
    for (int i = 0; i < 70; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = {16'(16'h8000 + i), 16'(i * 37 + 5)};
      tick();
    end
    bus.wr_valid = 1'b0;
    check("ovf_level", bus.fifo_level, 64);
    check("ovf_full", bus.fifo_full, 1);

    // Push on the boundary pop with the FIFO full
    wait_boundary();
    push(32'hCAFE_F00D);
    check("full_pushpop_level", bus.fifo_level, 64);
    check("full_pushpop_full", bus.fifo_full, 1);

    rx_mark = rx_count;
    run(10 * 1024 + 100);
    check("rx_active", (rx_count - rx_mark) >= 10, 1);
    phase_check("ovf");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
